// File: rtl/vga_sprite_overlay_if.sv
// Sprite position request channel: the requester (master) offers pos_x/pos_y
// qualified by pos_valid; the overlay (slave) answers with pos_ready.
interface vga_sprite_overlay_if;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic       pos_valid;
    logic       pos_ready;

    modport master (output pos_x, output pos_y, output pos_valid, input pos_ready);
    modport slave  (input pos_x, input pos_y, input pos_valid, output pos_ready);
endinterface

// File: rtl/vga_sprite_overlay.sv
// Three-stage sprite overlay for a VGA pixel stream with frame-synchronous position update.
// Optional macro SPRITE_SCALE2_EN doubles the footprint to 64x64 (2x2 pixels per texel).
module vga_sprite_overlay #(
    parameter int          SPR_W     = 32,
    parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
    input  logic                       pclk,
    input  logic                       reset,
    input  logic [9:0]                 h_cnt,
    input  logic [9:0]                 v_cnt,
    input  logic                       valid_in,
    input  logic                       hsync_in,
    input  logic                       vsync_in,
    vga_sprite_overlay_if.slave        pos,
    input  logic [11:0]                bg_color,
    output logic [9:0]                 rom_addr,
    input  logic [11:0]                rom_data,
    output logic [11:0]                rgb,
    output logic                       hsync_out,
    output logic                       vsync_out,
    output logic                       upd_state
);

`ifdef SPRITE_SCALE2_EN
    localparam int SPR = 2 * SPR_W;
`else
    localparam int SPR = SPR_W;
`endif
    localparam logic [10:0] SPR11 = 11'(SPR);

    // Handshake: a request transfers on a cycle where pos_valid && pos_ready.
    // pos_ready is low while an accepted position waits for the next vsync rising edge.
    typedef enum logic {UPD_IDLE = 1'b0, UPD_PENDING = 1'b1} upd_e;

    upd_e       state_q, state_d;
    logic [9:0] act_x, act_y, shd_x, shd_y;
    logic       vs_prev;
    logic       vs_rise;
    logic       accept, commit;

    assign vs_rise = vsync_in && !vs_prev;

    always_ff @(posedge pclk) begin
        if (reset) state_q <= UPD_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            UPD_IDLE:    if (pos.pos_valid) state_d = UPD_PENDING;
            UPD_PENDING: if (vs_rise)       state_d = UPD_IDLE;
            default:                        state_d = UPD_IDLE;
        endcase
    end

    always_comb begin
        pos.pos_ready = (state_q == UPD_IDLE);
        upd_state     = (state_q == UPD_PENDING);
        accept        = pos.pos_valid && (state_q == UPD_IDLE);
        commit        = vs_rise && (state_q == UPD_PENDING);
    end

    // Active position only moves at end of vsync so a frame never tears.
    always_ff @(posedge pclk) begin
        if (reset) begin
            act_x   <= '0;
            act_y   <= '0;
            shd_x   <= '0;
            shd_y   <= '0;
            vs_prev <= 1'b1;
        end else begin
            vs_prev <= vsync_in;
            if (accept) begin
                shd_x <= pos.pos_x;
                shd_y <= pos.pos_y;
            end
            if (commit) begin
                act_x <= shd_x;
                act_y <= shd_y;
            end
        end
    end

    // 11-bit compares keep a sprite near the right/bottom edge from wrapping to 0.
    logic       hit;
    logic [4:0] tex_x, tex_y;

    assign hit = valid_in
              && ({1'b0, h_cnt} >= {1'b0, act_x}) && ({1'b0, h_cnt} < ({1'b0, act_x} + SPR11))
              && ({1'b0, v_cnt} >= {1'b0, act_y}) && ({1'b0, v_cnt} < ({1'b0, act_y} + SPR11));

`ifdef SPRITE_SCALE2_EN
    assign tex_x = 5'((h_cnt[5:0] - act_x[5:0]) >> 1);
    assign tex_y = 5'((v_cnt[5:0] - act_y[5:0]) >> 1);
`else
    assign tex_x = h_cnt[4:0] - act_x[4:0];
    assign tex_y = v_cnt[4:0] - act_y[4:0];
`endif

    logic        hit1, val1, hs1, vs1;
    logic        hit2, val2, hs2, vs2;
    logic [11:0] pix_d;

    always_comb begin
        pix_d = bg_color;
        if (!val2)                              pix_d = 12'h000;
        else if (hit2 && rom_data != KEY_COLOR) pix_d = rom_data;
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            rom_addr  <= '0;
            hit1      <= 1'b0;
            val1      <= 1'b0;
            hs1       <= 1'b1;
            vs1       <= 1'b1;
            hit2      <= 1'b0;
            val2      <= 1'b0;
            hs2       <= 1'b1;
            vs2       <= 1'b1;
            rgb       <= '0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            if (hit) rom_addr <= {tex_y, tex_x};
            hit1      <= hit;
            val1      <= valid_in;
            hs1       <= hsync_in;
            vs1       <= vsync_in;
            // rom_data for the stage-1 address is valid while stage 2 holds its flags
            hit2      <= hit1;
            val2      <= val1;
            hs2       <= hs1;
            vs2       <= vs1;
            rgb       <= pix_d;
            hsync_out <= hs2;
            vsync_out <= vs2;
        end
    end

endmodule

// File: doc/vga_sprite_overlay.md
VGA_SPRITE_OVERLAY -- requirements
Module: vga_sprite_overlay

Interface
REQ-001 The block SHALL use clock pclk and reset reset, which is synchronous and active-high.
REQ-002 Port: pclk  input  1  pixel clock, 25 MHz.
REQ-003 Port: reset  input  1  synchronous active-high reset.
REQ-004 Port: h_cnt  input  10  column from the timing controller; reads 0 outside the active area.
REQ-005 Port: v_cnt  input  10  line from the timing controller; reads 0 outside the active area.
REQ-006 Port: valid_in  input  1  high when the current pixel is in the active area.
REQ-007 Port: hsync_in / vsync_in  input  1 each  sync pulses, active-low.
REQ-008 Port: pos_x / pos_y  input  10 each  requested sprite top-left position.
REQ-009 Port: pos_valid  input  1  position request; pos_ready  output  1  request accepted when both are high.
REQ-010 Port: bg_color  input  12  background RGB444.
REQ-011 Port: rom_addr  output  10  sprite ROM address; rom_data  input  12  ROM data, returned exactly 1 cycle after the address.
REQ-012 Port: rgb  output  12  final pixel; hsync_out / vsync_out  output  1 each  delayed syncs.
REQ-013 Parameter: SPR_W, default 32, sprite edge in pixels; fixed at 32 unless scaling is enabled.
REQ-014 Parameter: KEY_COLOR, default 12'hF0F, transparent colour key.

Function
REQ-015 The pipeline SHALL have 3 stages; rgb, hsync_out and vsync_out SHALL correspond to the inputs sampled exactly 3 cycles earlier.
REQ-016 Stage 1 SHALL register rom_addr, the hit flag, valid and both syncs.
- Stage 2 carries the delayed flags while rom_data arrives.
- Stage 3 registers rgb and the syncs.
REQ-017 The hit flag SHALL be: valid_in && h_cnt>=act_x && h_cnt<act_x+SPR && v_cnt>=act_y && v_cnt<act_y+SPR.
- SPR is the effective footprint: 32, or 64 with scaling.
- Compares are done in 11 bits, so a sprite near the right or bottom edge is clipped with no wrap.
REQ-018 On a hit, rom_addr SHALL be {dy[4:0], dx[4:0]}, where dx = h_cnt-act_x and dy = v_cnt-act_y. On a miss, rom_addr SHALL hold its previous value.
REQ-019 The rgb output SHALL be selected as follows:
- 0 when the delayed valid is low;
- rom_data when the delayed hit is high and rom_data != KEY_COLOR;
- bg_color otherwise.
REQ-020 Position handshake: pos_ready SHALL equal !pending. When pos_valid && pos_ready, pos_x and pos_y SHALL be captured into shadow registers and pending SHALL be set.
REQ-021 Commit: on the cycle where vsync_in is high and was low the previous cycle (end of the sync pulse), if pending is set, the shadow SHALL be copied into act_x/act_y and pending SHALL clear.
REQ-022 The active position SHALL never change between vsync rising edges; this prevents tearing within a frame.
REQ-023 Accept and commit in the same cycle cannot occur, because pos_ready=0 whenever pending=1.
REQ-024 pos_valid held high with pos_ready low SHALL have no effect.
REQ-025 Positions up to 1023 SHALL be accepted; a sprite wholly off-screen produces no hits.

Reset
REQ-026 On reset the block SHALL set:
- act_x, act_y, shadow and pending = 0, so pos_ready = 1 on the first cycle after reset;
- rom_addr = 0 and rgb = 0;
- hsync_out and vsync_out = 1, together with all pipeline sync stages;
- all pipeline valid and hit stages = 0.
REQ-027 Reset asserted mid-frame or mid-handshake SHALL discard any pending update and flush the pipeline within the same cycle.

Configuration
REQ-028 Macro SPRITE_SCALE2_EN:
- When defined, the footprint SHALL be 64x64, with each ROM texel covering a 2x2 block, and rom_addr = {dy[5:1], dx[5:1]}.
- When undefined, the footprint SHALL be 32x32 and REQ-018 applies unchanged.
- The ROM size is 1024 words in both cases.

Verification
REQ-029 Place the sprite at (100,50) and model the ROM as data = address:
- input pixel (100,50) -> rgb=12'h000, since address 0 holds data 0, which is not the key;
- input pixel (131,81) -> rgb=12'h3FF, 3 cycles later, with rom_addr=1023 one cycle after the pixel;
- input pixel (132,50) -> rgb=bg_color.
REQ-030 Return rom_data=12'hF0F on a hit with bg_color=12'h0A0 -> rgb=12'h0A0; a blanking pixel -> rgb=0.
REQ-031 Pulse pos_valid=1 with (200,200) mid-frame -> pos_ready drops the next cycle; the hit region stays at the old position until the vsync rising edge, then moves; pos_ready returns to 1.
REQ-032 Place the sprite at (630,470) -> hits only for h 630..639 and v 470..479; no hits at h=0..21 or v=0..21, confirming no wrap.
REQ-033 Assert reset for 1 cycle mid-frame with pending=1 -> next cycle rgb=0, hsync_out=1, vsync_out=1, pos_ready=1, position=(0,0).
REQ-034 With SPRITE_SCALE2_EN defined and the sprite at (0,0) -> pixels (2,0) and (3,0) both give rom_addr=1; pixel (63,63) gives rom_addr=1023; pixel (64,0) is a miss.
